// File: rtl/exec_unit_16bit.sv
// exec_unit_16bit: execute stage behind the 32x16 register file.
// Single-cycle ALU ops write back one cycle after accept with a WrEn pulse.
// Optional iterative shift-add multiply (opcode 9) is built only when the
// macro EXEC_MUL_EN is defined; otherwise opcode 9 is reported as illegal.
module exec_unit_16bit #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] Rw_in,
  input  logic [WIDTH-1:0]  busA,
  input  logic [WIDTH-1:0]  busB,
  output logic              busy,
  output logic [WIDTH-1:0]  busW,
  output logic [REG_AW-1:0] Rw,
  output logic              WrEn,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic              illegal
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_SLT = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;

  logic              accept;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  alu_r;
  logic              alu_c, alu_v, alu_ok;
  logic [SW-1:0]     shamt;

  logic [WIDTH-1:0]  busW_q, busW_d;
  logic [REG_AW-1:0] rw_q, rw_d;
  logic              wren_q, wren_d;
  logic              ill_q, ill_d;
  logic              fz_q, fz_d, fn_q, fn_d, fc_q, fc_d, fv_q, fv_d;

  assign accept = start && !busy;
  assign shamt  = busB[SW-1:0];

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [REG_AW-1:0]   rwp_q, rwp_d;
  logic [2*WIDTH-1:0]  prod;

  assign busy = (state_q == S_MUL);
  assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Multiplier state: FSM, iteration counter and shift-add datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rwp_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rwp_q    <= rwp_d;
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Single-cycle ALU result and arithmetic flags from the live operands
  always_comb begin
    sum    = '0;
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    alu_ok = 1'b1;
    case (opcode)
      OP_ADD: begin
        sum   = {1'b0, busA} + {1'b0, busB};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (busA[WIDTH-1] == busB[WIDTH-1]) && (alu_r[WIDTH-1] != busA[WIDTH-1]);
      end
      OP_SUB: begin
        // the 17th bit of the difference is the unsigned borrow
        sum   = {1'b0, busA} - {1'b0, busB};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (busA[WIDTH-1] != busB[WIDTH-1]) && (alu_r[WIDTH-1] != busA[WIDTH-1]);
      end
      OP_AND: alu_r = busA & busB;
      OP_OR:  alu_r = busA | busB;
      OP_XOR: alu_r = busA ^ busB;
      OP_SLL: alu_r = busA << shamt;
      OP_SRL: alu_r = busA >> shamt;
      OP_SRA: alu_r = $signed(busA) >>> shamt;
      OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(busA) < $signed(busB))};
`ifdef EXEC_MUL_EN
      OP_MUL: alu_ok = 1'b1;
`else
      OP_MUL: alu_ok = 1'b0;
`endif
      default: alu_ok = 1'b0;
    endcase
  end

  // Next-state: write-back registers, illegal pulse and multiply sequencing
  always_comb begin
    wren_d = 1'b0;
    ill_d  = 1'b0;
    busW_d = busW_q;
    rw_d   = rw_q;
    fz_d   = fz_q;
    fn_d   = fn_q;
    fc_d   = fc_q;
    fv_d   = fv_q;
`ifdef EXEC_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rwp_d    = rwp_q;
    case (state_q)
      S_MUL: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // last multiplier bit: register the product so WrEn lands in DONE
        if (cnt_q == SW'(WIDTH-1)) begin
          state_d = S_DONE;
          wren_d  = 1'b1;
          busW_d  = prod[WIDTH-1:0];
          rw_d    = rwp_q;
          fz_d    = (prod[WIDTH-1:0] == '0);
          fn_d    = prod[WIDTH-1];
          fc_d    = 1'b0;
          fv_d    = |prod[2*WIDTH-1:WIDTH];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`endif
    if (accept) begin
      if (!alu_ok) begin
        ill_d = 1'b1;
`ifdef EXEC_MUL_EN
      end else if (opcode == OP_MUL) begin
        state_d  = S_MUL;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, busA};
        mplier_d = busB;
        rwp_d    = Rw_in;
`endif
      end else begin
        wren_d = 1'b1;
        busW_d = alu_r;
        rw_d   = Rw_in;
        fz_d   = (alu_r == '0);
        fn_d   = alu_r[WIDTH-1];
        fc_d   = alu_c;
        fv_d   = alu_v;
      end
    end
  end

  // Write-back port and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busW_q <= '0;
      rw_q   <= '0;
      wren_q <= 1'b0;
      ill_q  <= 1'b0;
      fz_q   <= 1'b0;
      fn_q   <= 1'b0;
      fc_q   <= 1'b0;
      fv_q   <= 1'b0;
    end else begin
      busW_q <= busW_d;
      rw_q   <= rw_d;
      wren_q <= wren_d;
      ill_q  <= ill_d;
      fz_q   <= fz_d;
      fn_q   <= fn_d;
      fc_q   <= fc_d;
      fv_q   <= fv_d;
    end
  end

  assign busW    = busW_q;
  assign Rw      = rw_q;
  assign WrEn    = wren_q;
  assign illegal = ill_q;
  assign flag_z  = fz_q;
  assign flag_n  = fn_q;
  assign flag_c  = fc_q;
  assign flag_v  = fv_q;

endmodule

// File: tb/tb_exec_unit_16bit.sv
// Self-checking bench for exec_unit_16bit: directed vectors, randomized
// ops against an arithmetic reference model, illegal opcodes, reset, and
// (when EXEC_MUL_EN is defined) multiply timing, ignore-while-busy and abort.
module tb_exec_unit_16bit;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  opcode;
  logic [4:0]  Rw_in;
  logic [15:0] busA, busB;
  logic        busy, WrEn, flag_z, flag_n, flag_c, flag_v, illegal;
  logic [15:0] busW;
  logic [4:0]  Rw;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] exp_busW;
  logic [4:0]  exp_rw;
  logic        exp_z, exp_n, exp_c, exp_v;

  exec_unit_16bit dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .Rw_in(Rw_in),
    .busA(busA), .busB(busB), .busy(busy), .busW(busW), .Rw(Rw), .WrEn(WrEn),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  wire [27:0] obs = {WrEn, illegal, busy, busW, Rw, flag_z, flag_n, flag_c, flag_v};

  function automatic logic [27:0] expv(input logic we, input logic il, input logic bz);
    return {we, il, bz, exp_busW, exp_rw, exp_z, exp_n, exp_c, exp_v};
  endfunction

  // Reference model: results computed with plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c, output logic v,
                                output logic ok);
    int sa, sb, s;
    longint p;
    sa = $signed(a);
    sb = $signed(b);
    r = 16'h0; c = 1'b0; v = 1'b0; ok = 1'b1;
    case (op)
      4'h0: begin s = int'(a) + int'(b); r = s[15:0]; c = (s > 65535);
                  v = (sa + sb > 32767) || (sa + sb < -32768); end
      4'h1: begin s = int'(a) - int'(b); r = s[15:0]; c = (a < b);
                  v = (sa - sb > 32767) || (sa - sb < -32768); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: begin s = int'(a) << b[3:0]; r = s[15:0]; end
      4'h6: r = a >> b[3:0];
      4'h7: begin s = sa >>> b[3:0]; r = s[15:0]; end
      4'h8: r = (sa < sb) ? 16'd1 : 16'd0;
      4'h9: begin p = longint'(a) * longint'(b); r = p[15:0]; v = (p > 65535); ok = MUL_EN; end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic set_exp(input logic [15:0] r, input logic [4:0] rw, input logic c, input logic v);
    exp_busW = r; exp_rw = rw; exp_z = (r == 16'h0); exp_n = r[15]; exp_c = c; exp_v = v;
  endtask

  // Present one request; returns 1 ns after the accept edge (cycle T+1).
  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] rw);
    opcode = op; busA = a; busB = b; Rw_in = rw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    set_exp(16'h0, 5'd0, 1'b0, 1'b0);
    exp_z = 1'b0;
    n_chk++;
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL reset: got %h required %h", obs, 28'h0);
    end
  endtask

  logic [3:0]  d_op [7] = '{4'h0, 4'h1, 4'h1, 4'h7, 4'h8, 4'h5, 4'h6};
  logic [15:0] d_a  [7] = '{16'h7FFF, 16'h0005, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h8000};
  logic [15:0] d_b  [7] = '{16'h0001, 16'h0005, 16'h0002, 16'h0004, 16'h0001, 16'h0010, 16'h0013};
  logic [15:0] d_r  [7] = '{16'h8000, 16'h0000, 16'hFFFF, 16'hF800, 16'h0001, 16'h1234, 16'h1000};
  logic [3:0]  d_f  [7] = '{4'b0101, 4'b1000, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0000};

  task automatic test_directed();
    logic [27:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(d_op[i], d_a[i], d_b[i], 5'(i + 3));
      e = {3'b100, d_r[i], 5'(i + 3), d_f[i]};
      n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL directed[%0d] op=%h: got %h required %h", i, d_op[i], obs, e);
      end
    end
    set_exp(d_r[6], 5'd9, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_chk++;
    if (obs !== expv(1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL directed_hold: got %h required %h", obs, expv(1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] a, b, r;
    logic [4:0]  rw;
    logic        c, v, ok;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      if (MUL_EN && op == 4'h9) op = 4'h0;
      a = 16'($urandom); b = 16'($urandom); rw = 5'($urandom);
      if (($urandom & 3) == 0) a = b;
      model(op, a, b, r, c, v, ok);
      drive(op, a, b, rw);
      if (ok) set_exp(r, rw, c, v);
      n_chk++;
      if (obs !== expv(ok, !ok, 1'b0)) begin
        n_fail++;
        $display("FAIL random[%0d] op=%h a=%h b=%h: got %h required %h", i, op, a, b, obs, expv(ok, !ok, 1'b0));
      end
      if (($urandom % 3) == 0) begin
        @(posedge clk); #1;
        n_chk++;
        if (obs !== expv(1'b0, 1'b0, 1'b0)) begin
          n_fail++; $display("FAIL random_gap[%0d]: got %h required %h", i, obs, expv(1'b0, 1'b0, 1'b0));
        end
      end
    end
  endtask

  logic [3:0] il_ops [2] = '{4'hF, (MUL_EN ? 4'hA : 4'h9)};

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      drive(il_ops[i], 16'h1111, 16'h2222, 5'd30);
      n_chk++;
      if (obs !== expv(1'b0, 1'b1, 1'b0)) begin
        n_fail++; $display("FAIL illegal[%0d] op=%h: got %h required %h", i, il_ops[i], obs, expv(1'b0, 1'b1, 1'b0));
      end
      @(posedge clk); #1;
      n_chk++;
      if (obs !== expv(1'b0, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL illegal_pulse[%0d]: got %h required %h", i, obs, expv(1'b0, 1'b0, 1'b0));
      end
    end
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    logic [15:0] a, b, r, a2, b2, r2;
    logic [4:0]  rw, rw2;
    logic        c, v, ok, c2, v2, ok2;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 16'd300 : 16'($urandom);
      b = (i == 0) ? 16'd300 : 16'($urandom);
      rw = 5'($urandom);
      model(4'h9, a, b, r, c, v, ok);
      drive(4'h9, a, b, rw);
      for (int k = 1; k <= 16; k++) begin
        if (k == 5) begin
          opcode = 4'h0; busA = 16'h0001; busB = 16'h0001; Rw_in = 5'd0; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        n_chk++;
        if (obs[27:25] !== 3'b001) begin
          n_fail++; $display("FAIL mul_busy[%0d] T+%0d: got %b required 001", i, k, obs[27:25]);
        end
        @(posedge clk); #1;
      end
      // T+17: product written; a back-to-back ADD is accepted this cycle
      a2 = 16'($urandom); b2 = 16'($urandom); rw2 = 5'($urandom);
      model(4'h0, a2, b2, r2, c2, v2, ok2);
      opcode = 4'h0; busA = a2; busB = b2; Rw_in = rw2; start = 1'b1;
      set_exp(r, rw, c, v);
      n_chk++;
      if (obs !== expv(1'b1, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL mul_result[%0d] a=%h b=%h: got %h required %h", i, a, b, obs, expv(1'b1, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      start = 1'b0;
      set_exp(r2, rw2, c2, v2);
      n_chk++;
      if (obs !== expv(1'b1, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL mul_b2b[%0d]: got %h required %h", i, obs, expv(1'b1, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      n_chk++;
      if (obs !== expv(1'b0, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL mul_no_extra[%0d]: got %h required %h", i, obs, expv(1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_mul_reset();
    bit saw;
    drive(4'h9, 16'd300, 16'd300, 5'd9);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL mul_abort: got %h required %h", obs, 28'h0);
    end
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (WrEn !== 1'b0) saw = 1'b1;
    end
    n_chk++;
    if (saw !== 1'b0) begin
      n_fail++; $display("FAIL mul_abort_wren: got %b required 0", saw);
    end
    drive(4'h0, 16'd2, 16'd2, 5'd1);
    set_exp(16'd4, 5'd1, 1'b0, 1'b0);
    n_chk++;
    if (obs !== expv(1'b1, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL mul_abort_add: got %h required %h", obs, expv(1'b1, 1'b0, 1'b0));
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 4'h0; Rw_in = 5'd0; busA = 16'h0; busB = 16'h0;
    test_reset();
    test_directed();
    test_illegal();
    test_random();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_reset();
`endif
    test_illegal();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
